// File: rtl/sensor_hub.sv
// sensor_hub: measure tick generator, per-channel moving-average filters,
// staleness tracking and a snapshot frame with a valid/ready handshake.
module sensor_hub #(
    parameter int NCH         = 4,
    parameter int W           = 8,
    parameter int DEPTH       = 8,
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 8,
    parameter int STALE_TICKS = 3
) (
    input  logic               clk_50,
    input  logic               reset,
    input  logic [NCH*W-1:0]   raw_in,
    input  logic [NCH-1:0]     raw_valid,
    output logic               measure_pulse,
    output logic [NCH*W-1:0]   avg_out,
    output logic [NCH-1:0]     avg_valid,
    output logic [NCH-1:0]     stale,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic [NCH*W-1:0]   frame_data,
    output logic [NCH-1:0]     frame_stale,
    output logic [7:0]         overrun_cnt
);

    localparam int PERIOD = CLK_HZ / TICK_HZ;
    localparam int CW     = $clog2(PERIOD);
    localparam int LD     = $clog2(DEPTH);
    localparam int SW     = W + LD;
    localparam int FW     = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] TICK_TOP  = CW'(PERIOD - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
    localparam logic [7:0]    STALE_MAX = 8'(STALE_TICKS);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    // tick generator
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic          pulse_q, pulse_d;

    // per-channel filter state
    logic [W-1:0]  win_q  [NCH][DEPTH];
    logic [W-1:0]  win_d  [NCH][DEPTH];
    logic [LD-1:0] wptr_q [NCH];
    logic [LD-1:0] wptr_d [NCH];
    logic [SW-1:0] sum_q  [NCH];
    logic [SW-1:0] sum_d  [NCH];
    logic [FW-1:0] fill_q [NCH];
    logic [FW-1:0] fill_d [NCH];
    logic [W-1:0]  avg_q  [NCH];
    logic [W-1:0]  avg_d  [NCH];
    logic [NCH-1:0] avv_q, avv_d;

    // per-channel staleness state
    logic [7:0]     stc_q [NCH];
    logic [7:0]     stc_d [NCH];
    logic [NCH-1:0] stale_q, stale_d;

    // frame state
    state_t           state_q, state_d;
    logic [NCH*W-1:0] fdata_q, fdata_d;
    logic [NCH-1:0]   fstale_q, fstale_d;
    logic [7:0]       ovr_q, ovr_d;
    logic [NCH*W-1:0] avg_flat;

    // Free-running tick counter; pulse is registered so it lines up with count==PERIOD-1
    always_comb begin
        tick_cnt_d = (tick_cnt_q == TICK_TOP) ? '0 : tick_cnt_q + 1'b1;
        pulse_d    = (tick_cnt_d == TICK_TOP);
    end

    // Tick counter and pulse registers
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            pulse_q    <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            pulse_q    <= pulse_d;
        end
    end

    // Circular-window running sum; the oldest entry leaves as the new one lands
    always_comb begin
        win_d  = win_q;
        wptr_d = wptr_q;
        sum_d  = sum_q;
        fill_d = fill_q;
        avg_d  = avg_q;
        avv_d  = avv_q;
        for (int i = 0; i < NCH; i++) begin
            if (raw_valid[i]) begin
                sum_d[i] = sum_q[i]
                         + SW'(raw_in[i*W +: W])
                         - SW'(win_q[i][wptr_q[i]]);
                win_d[i][wptr_q[i]] = raw_in[i*W +: W];
                wptr_d[i] = wptr_q[i] + 1'b1;
                if (fill_q[i] != FILL_FULL) begin
                    fill_d[i] = fill_q[i] + 1'b1;
                end
            end
            avg_d[i] = sum_d[i][SW-1:LD];
            avv_d[i] = (fill_d[i] == FILL_FULL);
        end
    end

    // Filter registers, window entries included so restart is from empty
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    win_q[i][j] <= '0;
                end
                wptr_q[i] <= '0;
                sum_q[i]  <= '0;
                fill_q[i] <= '0;
                avg_q[i]  <= '0;
            end
            avv_q <= '0;
        end else begin
            win_q  <= win_d;
            wptr_q <= wptr_d;
            sum_q  <= sum_d;
            fill_q <= fill_d;
            avg_q  <= avg_d;
            avv_q  <= avv_d;
        end
    end

    // Ticks since last sample, saturating; a sample beats a coincident tick
    always_comb begin
        stc_d   = stc_q;
        stale_d = stale_q;
        for (int i = 0; i < NCH; i++) begin
            if (raw_valid[i]) begin
                stc_d[i] = '0;
            end else if (pulse_q && stc_q[i] != STALE_MAX) begin
                stc_d[i] = stc_q[i] + 8'd1;
            end
            stale_d[i] = (stc_d[i] == STALE_MAX);
        end
    end

    // Staleness registers
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                stc_q[i] <= '0;
            end
            stale_q <= '0;
        end else begin
            stc_q   <= stc_d;
            stale_q <= stale_d;
        end
    end

    // Flatten channel averages onto the output bus
    always_comb begin
        avg_flat = '0;
        for (int i = 0; i < NCH; i++) begin
            avg_flat[i*W +: W] = avg_q[i];
        end
    end

    // Frame FSM: snapshot on each tick; a tick while unaccepted counts an overrun
    always_comb begin
        state_d  = state_q;
        fdata_d  = fdata_q;
        fstale_d = fstale_q;
        ovr_d    = ovr_q;
        unique case (state_q)
            IDLE: begin
                if (pulse_q) begin
                    fdata_d  = avg_flat;
                    fstale_d = stale_q;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (pulse_q) begin
                    fdata_d  = avg_flat;
                    fstale_d = stale_q;
                    if (!frame_ready && ovr_q != 8'hFF) begin
                        ovr_d = ovr_q + 8'd1;
                    end
                end else if (frame_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame registers
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            fdata_q  <= '0;
            fstale_q <= '0;
            ovr_q    <= '0;
        end else begin
            state_q  <= state_d;
            fdata_q  <= fdata_d;
            fstale_q <= fstale_d;
            ovr_q    <= ovr_d;
        end
    end

    assign measure_pulse = pulse_q;
    assign avg_out       = avg_flat;
    assign avg_valid     = avv_q;
    assign stale         = stale_q;
    assign frame_valid   = (state_q == HOLD);
    assign frame_data    = fdata_q;
    assign frame_stale   = fstale_q;
    assign overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_sensor_hub.sv
// tb_sensor_hub: directed stimulus with cycle-tagged expectations and a
// frame scoreboard, checked by an independent negedge monitor.
module tb_sensor_hub;

    localparam int NCH         = 4;
    localparam int W           = 8;
    localparam int DEPTH       = 4;
    localparam int CLK_HZ      = 100;
    localparam int TICK_HZ     = 10;
    localparam int STALE_TICKS = 3;

    localparam int K_PULSE  = 0;
    localparam int K_AVG    = 1;
    localparam int K_AVV    = 2;
    localparam int K_STALE  = 3;
    localparam int K_FV     = 4;
    localparam int K_FDATA  = 5;
    localparam int K_FSTALE = 6;
    localparam int K_OVR    = 7;
    localparam int K_ZERO   = 8;

    logic               clk_50 = 1'b0;
    logic               reset;
    logic [NCH*W-1:0]   raw_in;
    logic [NCH-1:0]     raw_valid;
    logic               measure_pulse;
    logic [NCH*W-1:0]   avg_out;
    logic [NCH-1:0]     avg_valid;
    logic [NCH-1:0]     stale;
    logic               frame_valid;
    logic               frame_ready;
    logic [NCH*W-1:0]   frame_data;
    logic [NCH-1:0]     frame_stale;
    logic [7:0]         overrun_cnt;

    typedef struct {
        int          cyc;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  stl;
    } frm_t;

    exp_t chk_q[$];
    frm_t frm_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   gcyc = 0;
    bit   frame_chk = 1'b0;

    always #5 clk_50 = ~clk_50;

    always @(posedge clk_50) gcyc <= gcyc + 1;

    sensor_hub #(
        .NCH(NCH), .W(W), .DEPTH(DEPTH), .CLK_HZ(CLK_HZ),
        .TICK_HZ(TICK_HZ), .STALE_TICKS(STALE_TICKS)
    ) dut (
        .clk_50(clk_50),
        .reset(reset),
        .raw_in(raw_in),
        .raw_valid(raw_valid),
        .measure_pulse(measure_pulse),
        .avg_out(avg_out),
        .avg_valid(avg_valid),
        .stale(stale),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_data(frame_data),
        .frame_stale(frame_stale),
        .overrun_cnt(overrun_cnt)
    );

    function automatic logic [31:0] actual(input int kind, input int idx);
        case (kind)
            K_PULSE:  return 32'(measure_pulse);
            K_AVG:    return 32'(avg_out[idx*W +: W]);
            K_AVV:    return 32'(avg_valid);
            K_STALE:  return 32'(stale[idx]);
            K_FV:     return 32'(frame_valid);
            K_FDATA:  return frame_data;
            K_FSTALE: return 32'(frame_stale);
            K_OVR:    return 32'(overrun_cnt);
            default:  return 32'(|{measure_pulse, avg_out, avg_valid, stale,
                                   frame_valid, frame_data, frame_stale,
                                   overrun_cnt});
        endcase
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            K_PULSE:  return "measure_pulse";
            K_AVG:    return "avg_out";
            K_AVV:    return "avg_valid";
            K_STALE:  return "stale";
            K_FV:     return "frame_valid";
            K_FDATA:  return "frame_data";
            K_FSTALE: return "frame_stale";
            K_OVR:    return "overrun_cnt";
            default:  return "all_outputs_or";
        endcase
    endfunction

    task automatic exp_at(input int c, input int kind, input int idx,
                          input logic [31:0] val);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        chk_q.push_back(e);
    endtask

    task automatic exp_frame(input logic [31:0] d, input logic [3:0] s);
        frm_t f;
        f.data = d;
        f.stl  = s;
        frm_q.push_back(f);
    endtask

    task automatic step();
        @(posedge clk_50);
        #1;
    endtask

    task automatic goto_cyc(input int c);
        while (gcyc < c) step();
    endtask

    task automatic sample(input int ch, input logic [7:0] v);
        raw_in[ch*W +: W] = v;
        raw_valid[ch] = 1'b1;
        step();
        raw_valid = '0;
    endtask

    // Monitor: cycle-tagged checks plus frame handshake scoreboard
    always @(negedge clk_50) begin
        logic [31:0] a;
        frm_t        f;
        for (int k = chk_q.size() - 1; k >= 0; k--) begin
            if (chk_q[k].cyc == gcyc) begin
                a = actual(chk_q[k].kind, chk_q[k].idx);
                n_chk++;
                if (a !== chk_q[k].val) begin
                    n_fail++;
                    $display("FAIL %s[%0d] cyc %0d: got %0h want %0h",
                             kname(chk_q[k].kind), chk_q[k].idx, gcyc,
                             a, chk_q[k].val);
                end
                chk_q.delete(k);
            end
        end
        if (frame_chk && frame_valid && frame_ready) begin
            if (frm_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL frame_unexpected cyc %0d: got data %0h want none",
                         gcyc, frame_data);
            end else begin
                f = frm_q.pop_front();
                n_chk++;
                if (frame_data !== f.data) begin
                    n_fail++;
                    $display("FAIL frame_accept_data cyc %0d: got %0h want %0h",
                             gcyc, frame_data, f.data);
                end
                n_chk++;
                if (frame_stale !== f.stl) begin
                    n_fail++;
                    $display("FAIL frame_accept_stale cyc %0d: got %0h want %0h",
                             gcyc, frame_stale, f.stl);
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        raw_in      = '0;
        raw_valid   = '0;
        frame_ready = 1'b1;

        // reset state and tick cadence
        goto_cyc(2);
        exp_at(2, K_ZERO, 0, 32'h0);
        goto_cyc(3);
        reset = 1'b0;
        exp_at(3, K_ZERO, 0, 32'h0);
        exp_at(11, K_PULSE, 0, 32'h0);
        exp_at(12, K_PULSE, 0, 32'h1);
        exp_at(13, K_PULSE, 0, 32'h0);
        exp_at(22, K_PULSE, 0, 32'h1);
        exp_at(32, K_PULSE, 0, 32'h1);

        // ch0: 10,20,30,40 then 50
        goto_cyc(14);
        exp_at(15, K_AVG, 0, 32'd2);
        exp_at(16, K_AVG, 0, 32'd7);
        exp_at(17, K_AVG, 0, 32'd15);
        exp_at(17, K_AVV, 0, 32'h0);
        exp_at(18, K_AVG, 0, 32'd25);
        exp_at(18, K_AVV, 0, 32'h1);
        exp_at(19, K_AVG, 0, 32'd35);
        exp_at(19, K_AVV, 0, 32'h1);
        sample(0, 8'd10);
        sample(0, 8'd20);
        sample(0, 8'd30);
        sample(0, 8'd40);
        sample(0, 8'd50);

        // ch1: full scale x4 then 0
        goto_cyc(24);
        exp_at(27, K_AVG, 1, 32'd191);
        exp_at(28, K_AVG, 1, 32'd255);
        exp_at(28, K_AVV, 0, 32'h3);
        exp_at(29, K_AVG, 1, 32'd191);
        exp_at(29, K_AVV, 0, 32'h3);
        for (int i = 0; i < 4; i++) sample(1, 8'd255);
        sample(1, 8'd0);

        // staleness: ch2 idle for 3 ticks, sample on the 4th, then restart
        exp_at(32, K_STALE, 2, 32'h0);
        exp_at(33, K_STALE, 2, 32'h1);
        exp_at(42, K_STALE, 2, 32'h1);
        exp_at(43, K_STALE, 2, 32'h0);
        exp_at(63, K_STALE, 2, 32'h0);
        exp_at(72, K_STALE, 2, 32'h0);
        exp_at(73, K_STALE, 2, 32'h1);
        exp_at(42, K_STALE, 0, 32'h0);
        exp_at(43, K_STALE, 0, 32'h1);
        goto_cyc(42);
        exp_at(43, K_AVG, 2, 32'd25);
        sample(2, 8'd100);

        // frames: two ticks unaccepted, then accept, then ready on a tick
        goto_cyc(44);
        frame_ready = 1'b0;
        frame_chk   = 1'b1;
        exp_at(52, K_FV, 0, 32'h0);
        exp_at(53, K_FV, 0, 32'h1);
        exp_at(53, K_FDATA, 0, 32'h0019BF23);
        exp_at(53, K_FSTALE, 0, 32'h9);
        exp_at(53, K_OVR, 0, 32'd0);
        goto_cyc(55);
        exp_at(56, K_AVG, 3, 32'd10);
        sample(3, 8'd40);
        exp_at(63, K_FV, 0, 32'h1);
        exp_at(63, K_FDATA, 0, 32'h0A19BF23);
        exp_at(63, K_FSTALE, 0, 32'h3);
        exp_at(63, K_OVR, 0, 32'd1);
        exp_frame(32'h0A19BF23, 4'h3);
        goto_cyc(64);
        frame_ready = 1'b1;
        exp_at(64, K_FV, 0, 32'h1);
        exp_at(65, K_FV, 0, 32'h0);
        goto_cyc(70);
        frame_ready = 1'b0;
        exp_at(73, K_FV, 0, 32'h1);
        exp_at(73, K_FDATA, 0, 32'h0A19BF23);
        exp_frame(32'h0A19BF23, 4'h3);
        goto_cyc(75);
        exp_at(76, K_AVG, 0, 32'd47);
        sample(0, 8'd70);
        goto_cyc(82);
        frame_ready = 1'b1;
        exp_at(82, K_FV, 0, 32'h1);
        exp_at(83, K_FV, 0, 32'h1);
        exp_at(83, K_FDATA, 0, 32'h0A19BF2F);
        exp_at(83, K_FSTALE, 0, 32'h6);
        exp_at(83, K_OVR, 0, 32'd1);
        exp_at(84, K_FV, 0, 32'h0);
        exp_at(84, K_OVR, 0, 32'd1);
        exp_frame(32'h0A19BF2F, 4'h6);
        goto_cyc(84);
        frame_chk = 1'b0;

        // reset mid-fill on ch3, then refill with 8s
        goto_cyc(86);
        exp_at(87, K_AVG, 3, 32'd12);
        sample(3, 8'd8);
        goto_cyc(88);
        reset = 1'b1;
        exp_at(88, K_ZERO, 0, 32'h0);
        goto_cyc(90);
        reset = 1'b0;
        exp_at(98, K_PULSE, 0, 32'h0);
        exp_at(99, K_PULSE, 0, 32'h1);
        exp_at(94, K_AVG, 3, 32'd6);
        exp_at(94, K_AVV, 0, 32'h0);
        exp_at(95, K_AVG, 3, 32'd8);
        exp_at(95, K_AVV, 0, 32'h8);
        exp_at(95, K_AVG, 0, 32'd0);
        exp_at(100, K_FV, 0, 32'h1);
        exp_at(100, K_FDATA, 0, 32'h08000000);
        exp_at(100, K_OVR, 0, 32'd0);
        goto_cyc(91);
        for (int i = 0; i < 4; i++) sample(3, 8'd8);

        goto_cyc(103);
        foreach (chk_q[k]) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s[%0d] expired: no check at cyc %0d want %0h",
                     kname(chk_q[k].kind), chk_q[k].idx, chk_q[k].cyc,
                     chk_q[k].val);
        end
        foreach (frm_q[k]) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_missing: got no accept want data %0h",
                     frm_q[k].data);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
